// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, parity encodings and defaults.
// Used by both the transmit and the receive side of the UART.
package uart_pkg;

    // Parity selection values for the PARITY parameter
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Baud ticks per serial bit when the caller does not override it
    localparam int DEFAULT_OVERSAMPLE = 16;

    // Frame sequencing states, common to TX and RX
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Parity bit for up to 9 data bits. Unused upper bits must be zero.
    // Even parity returns the XOR of the data, so the total count of ones
    // (data + parity) is even. Odd parity returns its complement.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        logic ones;
        ones = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ones = ones ^ data[i];
        end
        return (mode == PARITY_ODD) ? ~ones : ones;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a data source and the UART transmitter.
// The source holds tx_valid and tx_data until tx_ready is seen high.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    // Data source side
    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    // Transmitter side
    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_bit_timer.sv
// Bit period timer: counts oversample ticks and flags the last tick of
// each serial bit. Clearing restarts the count so a new bit period begins
// on the next tick.
module tx_bit_timer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic clear,
    output logic bit_end
);

    localparam int              CW   = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]   LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // A tick arriving while clear is held is discarded, not counted
    assign bit_end = tick && !clear && (count_q == LAST);

    // Next count: hold, clear, or advance/wrap on tick
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick) begin
            if (count_q == LAST) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a word over a valid/ready handshake and sends
// start bit, DATA_BITS data bits LSB first, optional parity bit and
// STOP_BITS stop bits, each lasting OVERSAMPLE baud ticks. The line and
// handshake outputs are registered so tx never glitches.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = PARITY_NONE,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     tick,
    uart_tx_if.slave bus,
    output logic     tx,
    output logic     tx_busy
);

    // Bit index covers up to 9 data bits and up to 2 stop bits
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    uart_state_e          state_q,   state_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic                 parity_q,  parity_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic                 tx_q,      tx_d;
    logic                 ready_q,   ready_d;
    logic                 busy_q,    busy_d;

    logic accept;
    logic bit_end;
    logic timer_clear;

    assign accept      = bus.tx_valid && ready_q;
    // Holding the timer clear while idle drops any tick in the accept cycle,
    // so the start bit is timed from the edge that drives tx low.
    assign timer_clear = (state_q == ST_IDLE);

    tx_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .clear   (timer_clear),
        .bit_end (bit_end)
    );

    // Frame sequencing, shift register and parity, plus output values
    // derived from the next state so they register alongside it
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        bit_idx_d = bit_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d   = bus.tx_data;
                    parity_d  = parity_bit(9'(bus.tx_data), PARITY);
                    bit_idx_d = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q != LAST_DATA) begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end else begin
                        bit_idx_d = '0;
                        state_d   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_idx_q != LAST_STOP) begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end else begin
                        bit_idx_d = '0;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_d;
            default:   tx_d = 1'b1;
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // FSM and registered outputs; reset abandons any frame in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    assign bus.tx_ready = ready_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: the transmit-side counterpart of the receive sampling path. It accepts a parallel byte over a valid/ready handshake and shifts it out as one start bit, DATA_BITS data bits (LSB first), an optional parity bit and STOP_BITS stop bits. Bit timing comes from the shared 16x-oversample baud tick, so TX and RX run from the same baud generator.

## Interface
Parameters:
- DATA_BITS, 8, data bits per frame (5..9)
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits per frame (1 or 2)
- OVERSAMPLE, 16, baud ticks per serial bit (>= 2)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- tick  in  1  oversample baud enable, one-clk pulse
- tx_data  in  DATA_BITS  byte to send
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  block can accept a byte
- tx  out  1  serial line, idle high
- tx_busy  out  1  frame in progress

Reset: reset, asynchronous, active-high; clock clk.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Reset values: state = IDLE, tx = 1, tx_ready = 1, tx_busy = 0, bit/tick counters = 0, shift register = 0.
- IDLE:
  - tx = 1 and tx_ready = 1. tick is ignored.
  - On tx_valid && tx_ready (the accept cycle): latch tx_data into the shift register, compute the parity bit from the latched data, clear the tick counter, go to START.
- Tick counter: counts 0..OVERSAMPLE-1, incrementing only on tick.
  - Bit end = tick && count == OVERSAMPLE-1. The counter then wraps to 0.
- START: tx = 0. At bit end, go to DATA with bit index 0.
- DATA: tx = shift_reg[0]. At bit end, shift right.
  - If the index is below DATA_BITS-1, increment the index and stay.
  - Otherwise go to PARITY if PARITY != 0, else to STOP.
- PARITY: tx = parity bit.
  - Odd: the total count of ones (data + parity) is odd.
  - Even: the total count of ones is even.
  - At bit end, go to STOP.
- STOP: tx = 1 for STOP_BITS bit periods, then go to IDLE.
- Handshake outputs:
  - tx_ready = (state == IDLE).
  - tx_busy = !tx_ready.
  - tx_valid outside IDLE is ignored, and no data is lost: the source must hold tx_valid until ready.
  - Changes on tx_data after the accept cycle do not affect the frame in flight.
- tx is a registered output (glitch-free line). A reset asserted mid-frame returns tx to 1 and state to IDLE immediately, and the partial frame is abandoned.

## Timing
- tx falls on the first clk edge after the accept cycle.
- Every bit, the first included, lasts exactly OVERSAMPLE ticks counted from that edge.
- Frame length = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) × OVERSAMPLE ticks.
- tx_ready rises on the clk edge after the final stop-bit tick.
- Back-to-back frames: with tx_valid held high, the next accept occurs in the first IDLE cycle. Between frames there is exactly one extra clk of idle high beyond the stop bits.
- A tick coinciding with the accept cycle is not counted.

## Structure
- Shared package uart_pkg holds:
  - the state enum (shared with the RX FSM),
  - the parity encoding constants PARITY_NONE/ODD/EVEN,
  - the default OVERSAMPLE = 16.
- Sub-module tx_bit_timer: the tick counter with a clear input and a bit_end output. It is instanced once.
- The FSM, shift register and parity logic stay in uart_tx.

## Test plan
- 8N1, tick every clk, send 0xA5 -> tx shows 0, 1,0,1,0,0,1,0,1, 1, each level 16 clks. tx_ready is low for 160 clks, then high.
- Even parity, send 0x07 -> parity bit 1. Odd parity, send 0x07 -> parity bit 0. Frame is 11 bits.
- STOP_BITS=2, tick every 4 clks, send 0x00 -> start + 8 data bits low for 576 clks, then tx high for 128 clks before tx_ready rises.
- tx_valid held high with 0x55 then 0xAA -> two frames separated by exactly one extra idle clk. The second byte is accepted on the first IDLE cycle.
- Change tx_data and pulse tx_valid mid-frame -> transmitted bits unchanged, no second accept until IDLE.
- Assert reset during DATA bit 3 -> tx = 1, tx_ready = 1, tx_busy = 0 immediately. A new accept after reset sends a clean full frame.
